// File: rtl/fifo_pkg.sv
// Shared defaults and pointer-code helpers for the async FIFO.
// Gray/binary helpers work on a wide zero-extended word, so any pointer width up to PTR_MAX fits.
package fifo_pkg;
  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int PTR_W           = FIFO_ADDR_WIDTH + 1;
  localparam int PTR_MAX         = 16;

  typedef logic [PTR_MAX-1:0] ptr_wide_t;

  function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
    ptr_wide_t b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
endpackage

// File: rtl/fifo_out_buf.sv
// 2-entry prefetch buffer: push lands at the tail on the clock edge, head drives data.
// Zero-cycle pop; pushes only arrive when a slot is free because the reader caps outstanding words at two.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= push_data;
          else                 r_tail <= push_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // count is unchanged; the new word goes wherever the popped head leaves room
          if (r_count == 2'd1) begin
            r_head <= push_data;
          end else begin
            r_head <= r_tail;
            r_tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && r_count == 2'd2));

  assign count     = r_count;
  assign head_data = r_head;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: owns the read pointer, issues RAM reads, streams out.
// Data appears 2 cycles after a read is issued; at most 2 words are outstanding under backpressure.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   sync_wptr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         r_rbin;
  logic [PW-1:0]         r_rptr_gray;
  logic                  r_pending;

  logic [PW-1:0]         w_wbin;
  logic [PW-1:0]         w_level;
  logic [PW-1:0]         w_rbin_next;
  logic [1:0]            w_count;
  logic [1:0]            w_occ;
  logic [1:0]            w_occ_net;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_issue;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_wbin  = PW'(gray2bin(ptr_wide_t'(sync_wptr)));
  // Stale write pointer can only under-report, so a non-zero level always names written data.
  assign w_level = w_wbin - r_rbin;

  assign w_valid   = (w_count != 2'd0);
  assign w_pop     = w_valid & out_ready;
  assign w_occ     = w_count + {1'b0, r_pending};
  assign w_occ_net = w_occ - {1'b0, w_pop};
  assign w_issue   = (w_level != '0) && (w_occ_net < 2'd2);

  assign w_rbin_next = r_rbin + {{(PW-1){1'b0}}, w_issue};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rbin      <= '0;
      r_rptr_gray <= '0;
      r_pending   <= 1'b0;
    end else begin
      r_rbin      <= w_rbin_next;
      r_rptr_gray <= PW'(bin2gray(ptr_wide_t'(w_rbin_next)));
      r_pending   <= w_issue;
    end
  end

  fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (r_pending),
    .push_data (mem_rdata),
    .pop       (w_pop),
    .count     (w_count),
    .head_data (w_head)
  );

  assign rptr_gray = r_rptr_gray;
  assign mem_ren   = w_issue;
  assign mem_raddr = r_rbin[ADDR_WIDTH-1:0];
  assign out_valid = w_valid;
  assign out_data  = w_head;
  assign level     = w_level;
  assign empty     = (w_level == '0);

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the async FIFO, in the read clock domain.
- Owns the read pointer (binary and Gray).
- Consumes the write pointer already passed through the two-stage pointer synchroniser.
- Sequences reads from the dual-port RAM (1-cycle read latency) into a 2-entry prefetch buffer and presents a valid/ready stream.
- Exports the registered Gray read pointer for synchronisation into the write domain.

Parameters:
ADDR_WIDTH, 4, RAM address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
DATA_WIDTH, 8, RAM/stream data width.

Ports:
clk  in  1  read-domain clock.
rst  in  1  asynchronous, active-high reset.
sync_wptr  in  ADDR_WIDTH+1  Gray write pointer, already synchronised to clk.
rptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, sent to write domain.
mem_ren  out  1  RAM read enable.
mem_raddr  out  ADDR_WIDTH  RAM read address (= rbin[ADDR_WIDTH-1:0]).
mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after mem_ren.
out_valid  out  1  stream data valid.
out_ready  in  1  stream consumer ready.
out_data  out  DATA_WIDTH  stream data (buffer head).
level  out  ADDR_WIDTH+1  entries in RAM not yet fetched.
empty  out  1  level == 0.

Behaviour:
- Reset, asynchronous: rbin=0, rptr_gray=0, pending=0, buffer cleared. Outputs: out_valid=0, mem_ren=0, level=0, empty=1, out_data=0. An in-flight read is discarded. Both domains are reset together at system level.
- wbin = gray2bin(sync_wptr), combinational.
- level = (wbin - rbin) mod 2**(ADDR_WIDTH+1). Never exceeds 2**ADDR_WIDTH for legal inputs.
- pop = out_valid & out_ready.
- occ = buffer count (0..2) + pending (0/1).
- Issue (mem_ren=1) when level != 0 and occ - pop < 2. Combinational from registered state and sync_wptr.
- On issue:
  - rbin <= rbin+1.
  - pending <= 1 for the next cycle.
  - mem_raddr = current rbin low bits.
- rptr_gray <= bin2gray(rbin_next); it changes exactly one bit per issue.
- Cycle after issue: mem_rdata is written into the buffer tail at the clock edge, so out_valid is 1 two cycles after mem_ren.
- Buffer: 2-entry FIFO, head drives out_data.
  - Simultaneous push and pop keeps count unchanged.
  - Push into a full buffer cannot occur (guaranteed by the occ rule); assertion in sim.
- Throughput: one word per cycle with out_ready held high and level>0. Startup latency is 2 cycles from level becoming non-zero to out_valid.
- Backpressure: with out_ready=0, at most 2 reads are outstanding. out_data and out_valid stay stable until pop.
- Wrap-around: pointer MSB toggles every depth reads. Gray/binary math is modulo 2**(ADDR_WIDTH+1); level stays correct across wrap.
- sync_wptr is pessimistic (stale), so level/empty may under-report. They never over-report, so no read of unwritten data is possible.
- level is combinational from sync_wptr and rbin.

Decomposition:
- Package fifo_pkg:
  - ADDR_WIDTH/DATA_WIDTH defaults.
  - Functions bin2gray and gray2bin (width-generic via ADDR_WIDTH+1).
  - Pointer width constant PTR_W = ADDR_WIDTH+1.
- Sub-module fifo_out_buf: 2-entry valid/ready skid buffer.
  - Ports: push, push_data, pop, count, head_data.
  - Instantiated once; the controller owns pointers and issue logic.

Test Plan:
- Reset: assert rst mid-stream with pending=1 and buffer count 2 -> immediately out_valid=0, mem_ren=0, rptr_gray=0, empty=1. After release, no stale word appears.
- Single word: sync_wptr 00000->00001 at cycle 0, out_ready=1 -> mem_ren=1 with mem_raddr=0 in cycle 0; rptr_gray=00001 in cycle 1; out_valid=1 for exactly cycle 2 with out_data=RAM[0]; then empty=1.
- Streaming: RAM preloaded 0..7, sync_wptr=gray(8)=01100, out_ready=1 -> out_data 0,1,...,7 on 8 consecutive cycles starting 2 cycles after. Final rptr_gray=01100, level=0.
- Backpressure: sync_wptr=gray(8), out_ready=0 -> exactly 2 mem_ren pulses, then level=6. out_data holds RAM[0] stable. Releasing ready resumes with no gaps or duplicates.
- Wrap: stream 40 words through 16-deep RAM with sync_wptr advancing -> rbin wraps at 16 and 32. rptr_gray passes 11000 (16) and 110000-equivalent MSB toggle. All 40 words arrive in order.
- Stale pointer: hold sync_wptr at gray(3) while 5 words are written -> only 3 words are read. After the update to gray(5), 2 more are read. No read when level=0.
